// File: rtl/pingpong_buffer.sv
// Two-bank ping-pong frame buffer: the writer fills one bank while the reader
// drains the other, and each bank replays its stored frame length via out_last.
module pingpong_buffer #(
    parameter int DW    = 8,
    parameter int DEPTH = 16
) (
    input  logic          inclk0,
    input  logic          areset,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    input  logic          in_last,
    output logic          in_ready,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    output logic          out_last,
    input  logic          out_ready,
    output logic [1:0]    bank_full,
    output logic          wr_bank,
    output logic          rd_bank
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   LEN_ONE  = {{AW{1'b0}}, 1'b1};

    // Valid/ready: a word moves on a side exactly when valid and ready are both
    // high at the rising edge; valid never depends on ready on either side.
    logic [DW-1:0] mem [2*DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   len [2];
    logic [1:0]    full_q;
    logic [1:0]    full_d;
    logic          wr_bank_q;
    logic          rd_bank_q;
    logic          wr_fire;
    logic          wr_close;
    logic          rd_fire;
    logic          rd_close;
    logic [AW:0]   rd_len_m1;

    assign in_ready  = ~areset & ~full_q[wr_bank_q];
    assign wr_fire   = in_valid & in_ready;
    assign wr_close  = wr_fire & ((wr_ptr == LAST_PTR) | in_last);

    assign out_valid = full_q[rd_bank_q];
    assign out_data  = mem[{rd_bank_q, rd_ptr}];
    assign rd_len_m1 = len[rd_bank_q] - LEN_ONE;
    assign out_last  = out_valid & ({1'b0, rd_ptr} == rd_len_m1);
    assign rd_fire   = out_valid & out_ready;
    assign rd_close  = rd_fire & out_last;

    assign bank_full = full_q;
    assign wr_bank   = wr_bank_q;
    assign rd_bank   = rd_bank_q;

    // Close and release always target different banks, so both can apply.
    always_comb begin
        full_d = full_q;
        if (wr_close) full_d[wr_bank_q] = 1'b1;
        if (rd_close) full_d[rd_bank_q] = 1'b0;
    end

    always_ff @(posedge inclk0) begin
        if (wr_fire) mem[{wr_bank_q, wr_ptr}] <= in_data;
    end

    always_ff @(posedge inclk0) begin
        if (areset) begin
            full_q    <= 2'b00;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            len[0]    <= '0;
            len[1]    <= '0;
        end else begin
            full_q <= full_d;
            if (wr_close) begin
                len[wr_bank_q] <= {1'b0, wr_ptr} + LEN_ONE;
                wr_ptr         <= '0;
                wr_bank_q      <= ~wr_bank_q;
            end else if (wr_fire) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_close) begin
                rd_ptr    <= '0;
                rd_bank_q <= ~rd_bank_q;
            end else if (rd_fire) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end
endmodule

// File: tb/tb_pingpong_buffer.sv
// Directed bench for pingpong_buffer: inputs change and outputs are sampled on
// the falling edge, one task per scenario, with a summary line at the end.
module tb_pingpong_buffer;
    localparam int DW    = 8;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          areset;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_last;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_last;
    logic          out_ready;
    logic [1:0]    bank_full;
    logic          wr_bank;
    logic          rd_bank;

    int checks   = 0;
    int failures = 0;

    pingpong_buffer #(.DW(DW), .DEPTH(DEPTH)) dut (
        .inclk0    (clk),
        .areset    (areset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_ready (out_ready),
        .bank_full (bank_full),
        .wr_bank   (wr_bank),
        .rd_bank   (rd_bank)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        areset = 1'b1; in_valid = 1'b1; in_data = 8'hAA; in_last = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready cyc=%0d got=%b exp=0", i, in_ready); end
            checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid cyc=%0d got=%b exp=0", i, out_valid); end
            checks++; if (bank_full !== 2'b00) begin failures++; $display("FAIL reset_bank_full cyc=%0d got=%b exp=00", i, bank_full); end
        end
        areset = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL release_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL release_out_valid got=%b exp=0", out_valid); end
        checks++; if ({wr_bank, rd_bank} !== 2'b00) begin failures++; $display("FAIL release_banks got=%b%b exp=00", wr_bank, rd_bank); end
    endtask

    task automatic test_full_bank();
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            in_valid = 1'b1; in_data = DW'(i); in_last = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b0;
        checks++; if (bank_full !== 2'b01) begin failures++; $display("FAIL full0_bank_full got=%b exp=01", bank_full); end
        checks++; if (wr_bank !== 1'b1) begin failures++; $display("FAIL full0_wr_bank got=%b exp=1", wr_bank); end
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL full0_out_valid got=%b exp=1", out_valid); end
        checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL full0_out_data got=%h exp=00", out_data); end
        checks++; if (out_last !== 1'b0) begin failures++; $display("FAIL full0_out_last got=%b exp=0", out_last); end
        for (int i = 0; i < DEPTH; i++) begin
            checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL full1_in_ready i=%0d got=%b exp=1", i, in_ready); end
            in_valid = 1'b1; in_data = DW'(8'h10 + i);
            @(negedge clk);
        end
        in_valid = 1'b0;
        checks++; if (bank_full !== 2'b11) begin failures++; $display("FAIL full1_bank_full got=%b exp=11", bank_full); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL full1_in_ready_low got=%b exp=0", in_ready); end
    endtask

    task automatic test_drain();
        logic exp_last;
        out_ready = 1'b1;
        for (int k = 0; k < 2*DEPTH; k++) begin
            exp_last = (k == DEPTH-1) || (k == 2*DEPTH-1);
            checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL drain_valid k=%0d got=%b exp=1", k, out_valid); end
            checks++; if (out_data !== DW'(k)) begin failures++; $display("FAIL drain_data k=%0d got=%h exp=%h", k, out_data, DW'(k)); end
            checks++; if (out_last !== exp_last) begin failures++; $display("FAIL drain_last k=%0d got=%b exp=%b", k, out_last, exp_last); end
            checks++; if (in_ready !== (k >= DEPTH)) begin failures++; $display("FAIL drain_in_ready k=%0d got=%b exp=%b", k, in_ready, k >= DEPTH); end
            @(negedge clk);
        end
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL drain_end_valid got=%b exp=0", out_valid); end
        checks++; if (bank_full !== 2'b00) begin failures++; $display("FAIL drain_end_full got=%b exp=00", bank_full); end
        checks++; if ({wr_bank, rd_bank} !== 2'b00) begin failures++; $display("FAIL drain_end_banks got=%b%b exp=00", wr_bank, rd_bank); end
    endtask

    task automatic test_short_frame();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_data = DW'(8'h40 + i); in_last = (i == 4);
            @(negedge clk);
        end
        in_valid = 1'b0; in_last = 1'b0;
        checks++; if (bank_full !== 2'b01) begin failures++; $display("FAIL short_full got=%b exp=01", bank_full); end
        checks++; if (wr_bank !== 1'b1) begin failures++; $display("FAIL short_wr_bank got=%b exp=1", wr_bank); end
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL short_valid k=%0d got=%b exp=1", k, out_valid); end
            checks++; if (out_data !== DW'(8'h40 + k)) begin failures++; $display("FAIL short_data k=%0d got=%h exp=%h", k, out_data, DW'(8'h40 + k)); end
            checks++; if (out_last !== (k == 4)) begin failures++; $display("FAIL short_last k=%0d got=%b exp=%b", k, out_last, k == 4); end
            @(negedge clk);
        end
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL short_end_valid got=%b exp=0", out_valid); end
        checks++; if (rd_bank !== 1'b1) begin failures++; $display("FAIL short_rd_bank got=%b exp=1", rd_bank); end
    endtask

    task automatic test_streaming();
        logic [DW-1:0] exp_q[$];
        logic          exp_last_q[$];
        logic [DW-1:0] e_data;
        logic          e_last;
        logic          take;
        int            cnt  = 0;
        int            wpos = 0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 260; cyc++) begin
            @(negedge clk);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL stream_extra cyc=%0d got=%h exp=none", cyc, out_data);
                end else begin
                    e_data = exp_q.pop_front();
                    e_last = exp_last_q.pop_front();
                    checks++; if (out_data !== e_data) begin failures++; $display("FAIL stream_data cyc=%0d got=%h exp=%h", cyc, out_data, e_data); end
                    checks++; if (out_last !== e_last) begin failures++; $display("FAIL stream_last cyc=%0d got=%b exp=%b", cyc, out_last, e_last); end
                end
            end
            if (cyc <= 200) begin
                checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL stream_in_ready cyc=%0d got=%b exp=1", cyc, in_ready); end
            end
            take     = (cyc <= 200) && in_ready;
            in_valid = (cyc <= 200);
            in_last  = (cyc == 0) || (cyc == 200);
            in_data  = DW'(cnt);
            if (take) begin
                exp_q.push_back(DW'(cnt));
                exp_last_q.push_back(in_last || (wpos == DEPTH-1));
                wpos = (in_last || (wpos == DEPTH-1)) ? 0 : wpos + 1;
                cnt++;
            end
            if (cyc > 200 && exp_q.size() == 0) break;
        end
        in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL stream_drain remaining=%0d exp=0", exp_q.size()); end
    endtask

    task automatic test_mid_read_reset();
        areset = 1'b1; out_ready = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        areset = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            in_valid = 1'b1; in_data = DW'(8'h80 + i); in_last = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < DEPTH/2; k++) begin
            checks++; if (out_data !== DW'(8'h80 + k)) begin failures++; $display("FAIL mid_pre_data k=%0d got=%h exp=%h", k, out_data, DW'(8'h80 + k)); end
            @(negedge clk);
        end
        areset = 1'b1;
        @(negedge clk);
        checks++; if (bank_full !== 2'b00) begin failures++; $display("FAIL mid_full got=%b exp=00", bank_full); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_last !== 1'b0) begin failures++; $display("FAIL mid_out_last got=%b exp=0", out_last); end
        checks++; if ({wr_bank, rd_bank} !== 2'b00) begin failures++; $display("FAIL mid_banks got=%b%b exp=00", wr_bank, rd_bank); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL mid_in_ready_rst got=%b exp=0", in_ready); end
        areset = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL mid_in_ready_rel got=%b exp=1", in_ready); end
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = DW'(8'h90 + i); in_last = (i == 2);
            @(negedge clk);
        end
        in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL mid_post_valid k=%0d got=%b exp=1", k, out_valid); end
            checks++; if (out_data !== DW'(8'h90 + k)) begin failures++; $display("FAIL mid_post_data k=%0d got=%h exp=%h", k, out_data, DW'(8'h90 + k)); end
            checks++; if (out_last !== (k == 2)) begin failures++; $display("FAIL mid_post_last k=%0d got=%b exp=%b", k, out_last, k == 2); end
            @(negedge clk);
        end
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_end_valid got=%b exp=0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_full_bank();
        test_drain();
        test_short_frame();
        test_streaming();
        test_mid_read_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pingpong_buffer.md
# pingpong_buffer

Two-bank ping-pong frame buffer clocked from the system clock that the clock generator forwards (`c0`). It accepts a valid/ready input stream and writes one bank while the downstream side drains the other, then swaps banks. A frame can end early on `in_last`, and the stored length of each bank is replayed with `out_last` on the final word. This is the first data stage behind clock generation in the PINGPONG datapath.

## Interface
- `DW`, 8: data width in bits.
- `DEPTH`, 16: words per bank; a power of two, at least 2.
- `AW`, log2(`DEPTH`): pointer width; derived, not overridden.

Ports:
- `inclk0` in 1: single clock; all logic on its rising edge.
- `areset` in 1: reset, synchronous and active-high.
- `in_data` in DW: write data.
- `in_valid` in 1: write request.
- `in_last` in 1: marks the final word of a frame; qualified by `in_valid & in_ready`.
- `in_ready` out 1: buffer can accept a word this cycle.
- `out_data` out DW: read data.
- `out_valid` out 1: read data is available.
- `out_last` out 1: final word of the current bank; valid only when `out_valid` is high.
- `out_ready` in 1: downstream accepts the word.
- `bank_full` out 2: per-bank full flags (bit 0 = bank 0).
- `wr_bank` out 1: bank currently being written.
- `rd_bank` out 1: bank currently being read.

## Operation
- **Storage**
  - Memory is 2×DEPTH words, addressed {bank, ptr}.
  - Each bank has a registered `len` of AW+1 bits, holding 1..DEPTH.
- **Write side**
  - `in_ready = ~areset & ~bank_full[wr_bank]`.
  - On `in_valid & in_ready`: store at {wr_bank, wr_ptr}, then `wr_ptr++`.
- **Bank close**
  - A bank closes when `wr_ptr == DEPTH-1` or `in_last` is high on the accepted word.
  - On close, in the same cycle:
    - set `bank_full[wr_bank]`;
    - set `len[wr_bank] = wr_ptr+1`;
    - reset `wr_ptr` to 0;
    - toggle `wr_bank`.
  - If the newly selected bank is still full, `in_ready` drops until the reader releases it.
- **Read side**
  - `out_valid = bank_full[rd_bank]`.
  - `out_data = mem[{rd_bank, rd_ptr}]`; the read is combinational from the register array.
  - `out_last = out_valid & (rd_ptr == len[rd_bank]-1)`.
  - On `out_valid & out_ready`: `rd_ptr++`.
  - If `out_last` is high on that handshake:
    - clear `bank_full[rd_bank]`;
    - reset `rd_ptr` to 0;
    - toggle `rd_bank`.
- **Ordering:** banks are always consumed in the order they were filled. Reader and writer never target the same bank while it is full.
- **Input stalls:** `in_valid` low leaves all write-side state unchanged, so a bank may be partially filled indefinitely.
- **Illegal stimulus:**
  - `in_last` without `in_valid` is ignored.
  - `out_ready` while `out_valid` is low has no effect.

## Timing
- **Reset values, on the first edge with `areset=1`:**
  - `bank_full=2'b00`, `wr_bank=0`, `rd_bank=0`;
  - `wr_ptr=0`, `rd_ptr=0`, `len=0`;
  - `in_ready=0` while `areset` is high, then 1 on the cycle after deassertion;
  - `out_valid=0`, `out_last=0`.
  - Memory contents are not reset.
- **Reset mid-operation:** any partially written or partially read frame is discarded, and the state above is restored on that edge.
- **Latency:** the word that closes a bank is written at edge N. `out_valid` rises after edge N and the first word of that bank is presented in cycle N+1. The minimum write-close to first-read latency is 1 cycle.
- **Throughput:** one word per cycle per side. With both sides streaming continuously there is no bubble, provided the reader finishes bank X no later than the writer closes bank X^1.
- **Release bubble:** `bank_full` is registered. When the reader releases the bank the writer is waiting on, at edge M, `in_ready` rises in cycle M+1. There is no same-cycle pass-through.
- **Simultaneous close and release on different banks in one edge:** both flag updates apply; the set and the clear never target the same bit.
- **Wrap-around:**
  - `wr_ptr` and `rd_ptr` never exceed DEPTH-1.
  - A frame longer than DEPTH is split across banks. Each DEPTH-word chunk gets its own `out_last`.
- **Single-word frame:** `in_last` on the first word gives `len=1`, and `out_last` is asserted together with the first `out_valid`.

## Test plan
- **Reset:** hold `areset` for 3 cycles with `in_valid=1`. Expect:
  - no writes;
  - `in_ready=0`, `out_valid=0`, `bank_full=00` during reset;
  - `in_ready=1` on the first cycle after release.
- **Full bank (`DEPTH=16`, `out_ready=0`):** write 0x00..0x0F. Expect `bank_full=01`, `wr_bank=1`, `out_valid=1`, `out_data=0x00`. Write 16 more words; expect `bank_full=11` and `in_ready=0`.
- **Drain both banks:** from the previous state, set `out_ready=1`. Expect:
  - 0x00..0x0F, then the bank-1 data;
  - `out_last` on word 15 of each bank;
  - `in_ready` rising exactly one cycle after bank 0's `out_last` handshake.
- **Short frame:** 5 words with `in_last` on the 5th. Expect `len[0]=5`, a read sequence of 5 words with `out_last` on the 5th, and `rd_bank` toggling to 1.
- **Continuous streaming:** `in_valid=1` and `out_ready=1` for 200 cycles with an incrementing counter as data. Expect:
  - the output sequence equals the input sequence;
  - `in_ready` never drops after the first bank fills;
  - a single-word frame with `in_last` yields `out_valid` and `out_last` high together.
- **Mid-read reset:** assert `areset` for 1 cycle while bank 0 is half read. Expect all flags cleared and pointers 0. A following 3-word frame reads back correctly with `out_last` on word 3.
